// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared definitions for debug blocks that sit beside the cpu.
//   - mon_state_t : monitor state encodings (RUN / HALTED / TIMEOUT)
//   - cpu_st_t    : cpu state encodings as driven on the cpu's st output
//   - trace_w()   : width of one {PC, IR, ACC} trace record
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        MON_RUN     = 2'd0,
        MON_HALTED  = 2'd1,
        MON_TIMEOUT = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        CPU_ST_FETCH     = 2'd0,
        CPU_ST_EXECUTE   = 2'd1,
        CPU_ST_WRITEBACK = 2'd2,
        CPU_ST_IDLE      = 2'd3
    } cpu_st_t;

    function automatic int trace_w(input int pc_w, input int ir_w, input int data_w);
        return pc_w + ir_w + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port memory, one write port and one registered
// read port. A read and a write to the same address in the same cycle
// return the old contents (read-before-write).
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, one cycle after raddr
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 42,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // NOTE: the array has no reset so it maps onto RAM primitives; consumers
    // qualify rdata with their own valid tracking instead.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: taps the cpu debug outputs, records one {PC, IR, ACC}
// per retired instruction into a circular trace, counts cycles and retired
// instructions, and detects halt or a watchdog timeout.
//   clk, reset, clear : clock; synchronous active-high reset; synchronous restart
//   st, PC, IR, ACC   : cpu state and architectural debug taps
//   hlt               : cpu halt indication
//   rd_idx            : trace read index, 0 = oldest entry
//   rd_data, rd_valid : registered readback of the selected entry
//   mon_state         : 0 RUN, 1 HALTED, 2 TIMEOUT
//   cycle_cnt         : cycles spent in RUN (saturating)
//   instr_cnt         : captured instructions (saturating)
//   entries, full     : occupancy of the trace buffer
module cpu_trace_monitor
    import cpu_dbg_pkg::*;
#(
    parameter int         PC_W       = 10,
    parameter int         IR_W       = 16,
    parameter int         DATA_W     = 16,
    parameter int         DEPTH      = 16,
    parameter logic [1:0] CAPTURE_ST = 2'd1,
    parameter int         TIMEOUT    = 4096,
    parameter int         CNT_W      = 32,
    localparam int        AW         = $clog2(DEPTH),
    localparam int        TW         = trace_w(PC_W, IR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [1:0]        st,
    input  logic [PC_W-1:0]   PC,
    input  logic [IR_W-1:0]   IR,
    input  logic [DATA_W-1:0] ACC,
    input  logic              hlt,
    input  logic [AW-1:0]     rd_idx,
    output logic [TW-1:0]     rd_data,
    output logic              rd_valid,
    output logic [1:0]        mon_state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [AW:0]       entries,
    output logic              full
);

    localparam int              WD_W        = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT - 1);
    localparam logic [AW:0]     ENTRIES_MAX = (AW + 1)'(DEPTH);

    mon_state_t       state_q, state_d;
    logic [1:0]       st_prev;
    logic [AW-1:0]    wptr;
    logic [WD_W-1:0]  wd_cnt;
    logic             restart;
    logic             running;
    logic             retire;
    logic             capture;
    logic [AW-1:0]    rd_addr;
    logic             rd_hit;
    logic [TW-1:0]    ram_rdata;

    assign restart = reset | clear;
    assign running = (state_q == MON_RUN);
    // Edge-detect on entry to the capture state: a held state retires once.
    assign retire  = (st == CAPTURE_ST) && (st_prev != CAPTURE_ST);
    assign capture = running && retire && !restart;

    // Oldest entry sits at wptr - entries; natural AW-bit wrap gives mod DEPTH.
    assign rd_addr = wptr - entries[AW-1:0] + rd_idx;
    assign rd_hit  = ({1'b0, rd_idx} < entries);

    // NOTE: always_comb assigns every output a default first so no path
    // leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (state_q == MON_RUN) begin
            if (hlt) begin
                state_d = MON_HALTED;
            end else if (!retire && (wd_cnt == WD_LAST)) begin
                state_d = MON_TIMEOUT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= MON_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            st_prev   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            entries   <= '0;
            wptr      <= '0;
            wd_cnt    <= '0;
            rd_valid  <= 1'b0;
        end else begin
            st_prev  <= st;
            rd_valid <= rd_hit;
            if (running) begin
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                if (retire) begin
                    wptr   <= wptr + AW'(1);
                    wd_cnt <= '0;
                    if (entries != ENTRIES_MAX) begin
                        entries <= entries + (AW + 1)'(1);
                    end
                    if (instr_cnt != '1) begin
                        instr_cnt <= instr_cnt + CNT_W'(1);
                    end
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (TW)
    ) u_trace_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wptr),
        .wdata ({PC, IR, ACC}),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // RAM output is never reset; the registered hit flag masks stale data.
    assign rd_data   = rd_valid ? ram_rdata : '0;
    assign mon_state = state_q;
    assign full      = (entries == ENTRIES_MAX);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor. Two instances share stimulus:
// dut (TIMEOUT=4096) for capture/readback/halt/clear scenarios and dut_wd
// (TIMEOUT=8) for watchdog scenarios. Expected trace contents come from a
// model queue filled as retires are driven; readback expectations are queued
// when a read is issued and popped when the registered result appears.
module tb_cpu_trace_monitor;
    import cpu_dbg_pkg::*;

    localparam int PC_W   = 10;
    localparam int IR_W   = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 32;
    localparam int AW     = 4;
    localparam int TW     = PC_W + IR_W + DATA_W;

    typedef struct packed {
        logic [1:0]       state;
        logic [CNT_W-1:0] cycles;
        logic [CNT_W-1:0] instr;
        logic [AW:0]      entries;
        logic             full;
    } status_t;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] data;
    } rd_exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              hlt = 1'b0;
    logic [1:0]        st = 2'd0;
    logic [PC_W-1:0]   PC = '0;
    logic [IR_W-1:0]   IR = '0;
    logic [DATA_W-1:0] ACC = '0;
    logic [AW-1:0]     rd_idx = '0;

    logic [TW-1:0]     rd_data, rd_data_w;
    logic              rd_valid, rd_valid_w;
    logic [1:0]        mon_state, mon_state_w;
    logic [CNT_W-1:0]  cycle_cnt, cycle_cnt_w, instr_cnt, instr_cnt_w;
    logic [AW:0]       entries, entries_w;
    logic              full, full_w;

    int vectors = 0;
    int miscompares = 0;

    logic [TW-1:0] model_q[$];
    rd_exp_t       rd_exp_q[$];
    bit            model_run = 1'b1;

    always #5 clk = ~clk;

    cpu_trace_monitor #(
        .PC_W(PC_W), .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .CAPTURE_ST(2'd1), .TIMEOUT(4096), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .st(st), .PC(PC), .IR(IR),
        .ACC(ACC), .hlt(hlt), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .mon_state(mon_state), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt), .entries(entries), .full(full)
    );

    cpu_trace_monitor #(
        .PC_W(PC_W), .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .CAPTURE_ST(2'd1), .TIMEOUT(8), .CNT_W(CNT_W)
    ) dut_wd (
        .clk(clk), .reset(reset), .clear(clear), .st(st), .PC(PC), .IR(IR),
        .ACC(ACC), .hlt(hlt), .rd_idx(rd_idx), .rd_data(rd_data_w),
        .rd_valid(rd_valid_w), .mon_state(mon_state_w), .cycle_cnt(cycle_cnt_w),
        .instr_cnt(instr_cnt_w), .entries(entries_w), .full(full_w)
    );

    function automatic status_t mk(input logic [1:0] s, input int cyc, input int ins,
                                   input int ent, input logic f);
        status_t r;
        r.state   = s;
        r.cycles  = CNT_W'(cyc);
        r.instr   = CNT_W'(ins);
        r.entries = (AW + 1)'(ent);
        r.full    = f;
        return r;
    endfunction

    function automatic string fmt(input status_t s);
        return $sformatf("state=%0d cycles=%0d instr=%0d entries=%0d full=%b",
                         s.state, s.cycles, s.instr, s.entries, s.full);
    endfunction

    function automatic status_t snap_main();
        return {mon_state, cycle_cnt, instr_cnt, entries, full};
    endfunction

    function automatic status_t snap_wd();
        return {mon_state_w, cycle_cnt_w, instr_cnt_w, entries_w, full_w};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart(input bit use_reset, input bit use_clear);
        reset = use_reset;
        clear = use_clear;
        step();
        reset = 1'b0;
        clear = 1'b0;
        model_q.delete();
        model_run = 1'b1;
    endtask

    // One instruction: st 0 -> 1 -> 2, capture happens on the st=1 edge.
    task automatic retire(input logic [PC_W-1:0] pc, input logic [IR_W-1:0] ir,
                          input logic [DATA_W-1:0] acc);
        st = 2'd0;
        step();
        st  = 2'd1;
        PC  = pc;
        IR  = ir;
        ACC = acc;
        if (model_run) begin
            model_q.push_back({pc, ir, acc});
            if (model_q.size() > DEPTH) model_q.delete(0);
        end
        step();
        st = 2'd2;
        step();
    endtask

    task automatic test_readback(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_exp_t e;
            rd_idx = AW'(i);
            if (i < model_q.size()) begin
                e.valid = 1'b1;
                e.data  = model_q[i];
            end else begin
                e.valid = 1'b0;
                e.data  = '0;
            end
            rd_exp_q.push_back(e);
            step();
            e = rd_exp_q.pop_front();
            vectors++;
            if (rd_valid !== e.valid || rd_data !== e.data) begin
                miscompares++;
                $display("FAIL %s rd_idx=%0d: got valid=%b data=%h, want valid=%b data=%h",
                         tag, i, rd_valid, rd_data, e.valid, e.data);
            end
        end
    endtask

    task automatic test_reset();
        status_t got, exp;
        reset = 1'b1;
        st = 2'd1;
        step();
        step();
        got = snap_main();
        exp = mk(MON_RUN, 0, 0, 0, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_status: got %s, want %s", fmt(got), fmt(exp));
        end
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_read: got valid=%b data=%h, want valid=0 data=0", rd_valid, rd_data);
        end
        st = 2'd0;
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic test_basic();
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) retire(PC_W'(i), IR_W'(16'h1000 + i), DATA_W'(i));
        got = snap_main();
        exp = mk(MON_RUN, 15, 5, 5, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL basic_status: got %s, want %s", fmt(got), fmt(exp));
        end
        test_readback("basic_read");
    endtask

    task automatic test_wrap();
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) retire(PC_W'(i), IR_W'(16'h1000 + i), DATA_W'(i));
        got = snap_main();
        exp = mk(MON_RUN, 60, 20, 16, 1'b1);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL wrap_status: got %s, want %s", fmt(got), fmt(exp));
        end
        rd_idx = 4'd0;
        step();
        vectors++;
        if (rd_data[TW-1 -: PC_W] !== 10'h004) begin
            miscompares++;
            $display("FAIL wrap_oldest_pc: got %h, want 004", rd_data[TW-1 -: PC_W]);
        end
        rd_idx = 4'd15;
        step();
        vectors++;
        if (rd_data[TW-1 -: PC_W] !== 10'h013) begin
            miscompares++;
            $display("FAIL wrap_newest_pc: got %h, want 013", rd_data[TW-1 -: PC_W]);
        end
        test_readback("wrap_read");
    endtask

    task automatic test_hold();
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        st  = 2'd1;
        PC  = 10'h155;
        IR  = 16'h7A7A;
        ACC = 16'h0042;
        model_q.push_back({PC, IR, ACC});
        repeat (10) step();
        got = snap_main();
        exp = mk(MON_RUN, 10, 1, 1, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL hold_status: got %s, want %s", fmt(got), fmt(exp));
        end
        st = 2'd2;
        test_readback("hold_read");
    endtask

    task automatic test_halt();
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) retire(PC_W'(10'h100 + i), IR_W'(16'h2000 + i), DATA_W'(16'hA0 + i));
        hlt = 1'b1;
        step();
        hlt = 1'b0;
        model_run = 1'b0;
        got = snap_main();
        exp = mk(MON_HALTED, 10, 3, 3, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL halt_enter: got %s, want %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 2; i++) retire(PC_W'(10'h3FF - i), 16'hDEAD, 16'hBEEF);
        got = snap_main();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL halt_frozen: got %s, want %s", fmt(got), fmt(exp));
        end
        test_readback("halt_read");
    endtask

    task automatic test_watchdog(input bit hlt_on_trip);
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        st = 2'd0;
        step();
        st = 2'd1;
        PC = 10'h0AB;
        step();
        st = 2'd2;
        repeat (7) step();
        got = snap_wd();
        exp = mk(MON_RUN, 9, 1, 1, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL wd_pre_trip(hlt=%0b): got %s, want %s", hlt_on_trip, fmt(got), fmt(exp));
        end
        hlt = hlt_on_trip;
        step();
        hlt = 1'b0;
        got = snap_wd();
        exp = mk(hlt_on_trip ? MON_HALTED : MON_TIMEOUT, 10, 1, 1, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL wd_trip(hlt=%0b): got %s, want %s", hlt_on_trip, fmt(got), fmt(exp));
        end
        repeat (5) step();
        got = snap_wd();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL wd_sticky(hlt=%0b): got %s, want %s", hlt_on_trip, fmt(got), fmt(exp));
        end
    endtask

    task automatic test_clear(input bit with_reset);
        status_t got, exp;
        pulse_restart(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) retire(PC_W'(10'h050 + i), IR_W'(16'h3000 + i), DATA_W'(i));
        pulse_restart(with_reset, 1'b1);
        got = snap_main();
        exp = mk(MON_RUN, 0, 0, 0, 1'b0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL clear_status(reset=%0b): got %s, want %s", with_reset, fmt(got), fmt(exp));
        end
        retire(10'h2AA, 16'hBEEF, 16'h1234);
        test_readback(with_reset ? "reset_clear_read" : "clear_read");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_halt();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_clear(1'b0);
        test_clear(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: bench did not complete within time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/cpu_trace_monitor.md
Name: cpu_trace_monitor

Overview:
Parametrised, synthesizable execution monitor that sits beside the cpu core and taps its debug outputs (st, PC, IR, ACC, hlt).
- Captures one {PC, IR, ACC} record per executed instruction into a circular trace buffer.
- Counts cycles and retired instructions.
- Detects halt, and flags a watchdog timeout when no instruction retires within a set window.
- Trace contents are readable through an indexed port after the run, so benches and hardware debug share one checker.

Parameters:
PC_W, 10, program-counter width
IR_W, 16, instruction-register width
DATA_W, 16, accumulator width
DEPTH, 16, trace entries; power of two, at least 2
CAPTURE_ST, 2'd1, value of st that marks an instruction retiring
TIMEOUT, 4096, idle cycles before watchdog trip; at least 2
CNT_W, 32, width of the cycle and instruction counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous restart: same effect as reset, reset has priority
st  in  2  cpu state
PC  in  PC_W  cpu program counter
IR  in  IR_W  cpu instruction register
ACC  in  DATA_W  cpu accumulator
hlt  in  1  cpu halt indication
rd_idx  in  log2(DEPTH)  trace read index, 0 = oldest entry
rd_data  out  PC_W+IR_W+DATA_W  entry {PC,IR,ACC}, registered
rd_valid  out  1  rd_data holds a real entry
mon_state  out  2  0 RUN, 1 HALTED, 2 TIMEOUT
cycle_cnt  out  CNT_W  cycles spent in RUN, saturating
instr_cnt  out  CNT_W  captured instructions, saturating
entries  out  log2(DEPTH)+1  valid entries in buffer, 0..DEPTH
full  out  1  entries == DEPTH

Behaviour:
- Reset or clear values: mon_state=RUN, cycle_cnt=0, instr_cnt=0, entries=0, write pointer=0, watchdog=0, st_prev=0, rd_data=0, rd_valid=0. Buffer RAM contents are not cleared.
- Retire event: st==CAPTURE_ST && st_prev!=CAPTURE_ST, where st_prev is st registered one cycle.
  - A state held for N cycles produces one capture.
  - A retire in the first cycle after reset counts, because st_prev=0 and CAPTURE_ST must be non-zero.
- RUN state, every cycle:
  - cycle_cnt increments, saturating at all-ones.
  - On a retire: write {PC,IR,ACC} at the write pointer, advance the pointer modulo DEPTH, increment entries (saturating at DEPTH), increment instr_cnt (saturating), and zero the watchdog.
  - Without a retire, the watchdog increments.
  - Once the buffer is full, each new capture overwrites the oldest entry.
- Transitions out of RUN:
  - hlt=1 → HALTED on the next edge. The cycle in which hlt is sampled is still counted, and a retire in that same cycle is still captured.
  - watchdog==TIMEOUT-1 with no retire this cycle → TIMEOUT. Trips after TIMEOUT cycles without a retire.
  - hlt and watchdog trip in the same cycle: HALTED wins.
- HALTED and TIMEOUT are sticky until reset or clear. All counters, the buffer and the pointer freeze.
- Readback:
  - Valid in every state, with 1-cycle latency.
  - If rd_idx < entries: rd_data = buffer[(wptr - entries + rd_idx) mod DEPTH] and rd_valid=1.
  - Otherwise rd_data=0 and rd_valid=0.
  - A read of the slot being written in the same cycle returns the old contents (read-before-write).
- Arithmetic:
  - Pointer arithmetic is modulo DEPTH, using the natural log2(DEPTH)-bit wrap.
  - Internal widths are unsigned, with no sign extension.
  - The watchdog counter is $clog2(TIMEOUT)+1 bits wide.
- A reset or clear mid-run discards all state immediately. A retire in the reset cycle is not captured.

Decomposition:
- Shared package cpu_dbg_pkg:
  - mon_state encodings: MON_RUN=2'd0, MON_HALTED=2'd1, MON_TIMEOUT=2'd2.
  - cpu state encodings, matching the cpu's st values.
  - trace record width function PC_W+IR_W+DATA_W.
- One sub-module, trace_ram:
  - Parameters DEPTH and W.
  - Single write port, single registered read port, read-before-write.
  - Keeps the memory inferable and reusable by later debug blocks.
- Everything else (state machine, counters, pointer/entries logic, watchdog) lives in cpu_trace_monitor.

Test Plan:
- Reset, then drive 5 retires (st pulsing 0→1→2, PC 0x000..0x004, IR 0x1000+i, ACC i) → entries=5, instr_cnt=5, full=0; rd_idx 0..4 return {PC,IR,ACC} in order with rd_valid=1; rd_idx=5 gives rd_valid=0, rd_data=0.
- 20 retires with DEPTH=16 → entries=16, full=1, instr_cnt=20; rd_idx=0 returns the PC=0x004 entry and rd_idx=15 returns the PC=0x013 entry.
- Hold st=CAPTURE_ST for 10 cycles → exactly one capture; cycle_cnt advances by 10.
- Assert hlt after 3 retires → mon_state=1 next cycle; further st pulses leave instr_cnt=3 and cycle_cnt unchanged; readback still works.
- TIMEOUT=8 with no retire after one capture → mon_state=2 exactly 8 cycles after that capture. Repeat with hlt on the trip cycle → mon_state=1.
- Mid-run clear after 4 captures → entries=0, instr_cnt=0, cycle_cnt=0, mon_state=0; the next retire lands at rd_idx=0. Repeat with reset and clear asserted together → identical result.
